// File: rtl/slc_pkg.sv
// Shared SLC request-path types: the request flit layout and a channel-index
// width helper that stays legal for a single channel.
package slc_pkg;

  typedef struct packed {
    logic [3:0] qos;
    logic [3:0] opcode;
    logic [7:0] txn_id;
  } reqflit_t;

  function automatic int ch_width(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/slc_txreq_fifo.sv
// Per-channel synchronous request FIFO. Head reads as zero when empty, flush
// clears pointers and count and discards that cycle's push and pop.
module slc_txreq_fifo #(
  parameter  int DEPTH  = 2,
  parameter  int FLIT_W = 16,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [FLIT_W-1:0] din,
  output logic [FLIT_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [FLIT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push_s, do_pop_s;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign dout      = empty ? '0 : mem_q[rd_ptr_q];
  // A full FIFO refuses a push even when the same cycle pops it.
  assign do_push_s = push && !full && !flush;
  assign do_pop_s  = pop && !empty && !flush;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/slc_txreq_arb.sv
// Multi-channel SLC TXREQ stage: one FIFO per producer, merged onto a single
// TXREQ output by a round-robin arbiter whose grant is held across stalls.
module slc_txreq_arb
  import slc_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DEPTH  = 2,
  parameter  int FLIT_W = $bits(reqflit_t),
  localparam int CH_W   = ch_width(NUM_CH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [NUM_CH-1:0]              pin_valid,
  output logic [NUM_CH-1:0]              pin_ready,
  input  logic [NUM_CH-1:0][FLIT_W-1:0]  pin_data,
  output logic                           pout_valid,
  input  logic                           pout_ready,
  output logic [FLIT_W-1:0]              pout_data,
  output logic [CH_W-1:0]                pout_ch,
  output logic [NUM_CH-1:0][CNT_W-1:0]   ch_count
);

  logic [NUM_CH-1:0]             full_s, empty_s, push_s, pop_s;
  logic [NUM_CH-1:0][FLIT_W-1:0] head_s;
  logic [CH_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]               held_q, held_d;
  logic                          lock_q, lock_d;
  logic [CH_W-1:0]               grant_s;
  logic [CH_W:0]                 idx_s;
  logic                          found_s;
  logic                          hs_s;

  // Ready depends only on FIFO state, flush and reset, never on pout_ready.
  assign pin_ready  = ~full_s & {NUM_CH{reset && !flush}};
  assign push_s     = pin_valid & pin_ready;
  assign pout_valid = (|(~empty_s)) && reset && !flush;
  assign hs_s       = pout_valid && pout_ready;
  assign pout_data  = head_s[grant_s];
  assign pout_ch    = grant_s;

  // First non-empty channel at or after rr_ptr; a stalled grant overrides it.
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx_s = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
      if (idx_s >= (CH_W+1)'(NUM_CH)) begin
        idx_s = idx_s - (CH_W+1)'(NUM_CH);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && !empty_s[idx_s[CH_W-1:0]]) begin
        found_s = 1'b1;
        grant_s = idx_s[CH_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
    if (lock_q) begin
      grant_s = held_q;
    end else begin
      grant_s = grant_s;
    end
  end

  // Round-robin pointer advance and stall lock tracking.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    lock_d   = lock_q;
    held_d   = held_q;
    if (flush) begin
      rr_ptr_d = '0;
      lock_d   = 1'b0;
      held_d   = '0;
    end else if (hs_s) begin
      rr_ptr_d = (grant_s == CH_W'(NUM_CH - 1)) ? '0 : grant_s + CH_W'(1);
      lock_d   = 1'b0;
      held_d   = '0;
    end else if (pout_valid) begin
      lock_d   = 1'b1;
      held_d   = grant_s;
    end else begin
      lock_d   = 1'b0;
      held_d   = held_q;
    end
  end

  // Arbiter state registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      lock_q   <= 1'b0;
      held_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      lock_q   <= lock_d;
      held_q   <= held_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign pop_s[i] = hs_s && (grant_s == CH_W'(i));

    slc_txreq_fifo #(
      .DEPTH  (DEPTH),
      .FLIT_W (FLIT_W)
    ) u_fifo (
      .clock  (clock),
      .rst_n  (reset),
      .flush  (flush),
      .push   (push_s[i]),
      .pop    (pop_s[i]),
      .din    (pin_data[i]),
      .dout   (head_s[i]),
      .full   (full_s[i]),
      .empty  (empty_s[i]),
      .count  (ch_count[i])
    );
  end

endmodule
